// File: rtl/node_voltage_engine.sv
// Node voltage engine: walks num_nodes head entries and writes int(scale * (offset + matrix)) per valid head.
// Optional build macro NODE_VOLTAGE_COUNT_EN adds the valid_count output.
module node_voltage_engine #(
  parameter int          NODE_W       = 5,
  parameter int          HEAD_W       = 64,
  parameter int          REF_LSB      = 37,
  parameter int          MAT_AW       = 12,
  parameter int          RAM_LAT      = 2,
  parameter int          ADD_LAT      = 7,
  parameter int          MUL_LAT      = 5,
  parameter int          CVT_LAT      = 6,
  parameter logic [31:0] SCALE_CUSTOM = 32'h3F800000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        scale_sel,
  input  logic [NODE_W:0]   num_nodes,
  input  logic [NODE_W-1:0] num_ref_nodes,
  output logic              busy,
  output logic              done,
  output logic [NODE_W-1:0] nodeHeads_addr,
  input  logic [HEAD_W-1:0] nodeHeads_out,
  output logic [MAT_AW-1:0] matrix_addr,
  input  logic [31:0]       matrix_out,
  output logic [NODE_W-1:0] nodeVoltage_addr,
  output logic [31:0]       nodeVoltage_data,
  output logic              nodeVoltage_wren,
  output logic [31:0]       adder_data_a,
  output logic [31:0]       adder_data_b,
  input  logic [31:0]       adder_out,
  output logic [31:0]       multiplier_data_a,
  output logic [31:0]       multiplier_data_b,
  input  logic [31:0]       multiplier_out,
  output logic [31:0]       fp_to_int_data,
  input  logic [31:0]       fp_to_int_out,
`ifdef NODE_VOLTAGE_COUNT_EN
  output logic [NODE_W:0]   valid_count,
`endif
  output logic [2:0]        dbg_state
);

  localparam int CNT_W  = 16;
  localparam int OP_LAT = ADD_LAT + MUL_LAT + CVT_LAT;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_MREAD, S_COMPUTE, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NODE_W:0]     index_q, index_d;
  logic [NODE_W:0]     nn_q;
  logic [NODE_W-1:0]   nrn_q;
  logic [31:0]         scale_q;
  logic [NODE_W-1:0]   ref_q;
  logic [31:0]         off_q;
  logic [31:0]         mat_q;
  logic [31:0]         scale_pick;
  logic                accept, head_latch, mat_latch;
  logic                unused_head;

  // Only the valid bit, reference field and offset of a head word are consumed.
  assign unused_head = ^nodeHeads_out;

  always_comb begin
    scale_pick = SCALE_CUSTOM;
    case (scale_sel)
      2'd0:    scale_pick = 32'h3F800000;
      2'd1:    scale_pick = 32'h447A0000;
      2'd2:    scale_pick = 32'h3A83126F;
      default: scale_pick = SCALE_CUSTOM;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    index_d    = index_q;
    accept     = 1'b0;
    head_latch = 1'b0;
    mat_latch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          index_d = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Only reachable with index == count when the pass was started with zero nodes.
        if (index_q == nn_q) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CHECK: begin
        if (nodeHeads_out[HEAD_W-1]) begin
          head_latch = 1'b1;
          state_d    = S_MREAD;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_MREAD: begin
        if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
          mat_latch = 1'b1;
          cnt_d     = '0;
          state_d   = S_COMPUTE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == CNT_W'(OP_LAT - 1)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        index_d = index_q + {{NODE_W{1'b0}}, 1'b1};
        state_d = (index_d == nn_q) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      nn_q    <= '0;
      nrn_q   <= '0;
      scale_q <= '0;
      ref_q   <= '0;
      off_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      if (accept) begin
        nn_q    <= num_nodes;
        nrn_q   <= num_ref_nodes;
        scale_q <= scale_pick;
      end
      if (head_latch) begin
        off_q <= nodeHeads_out[31:0];
        ref_q <= nodeHeads_out[REF_LSB +: NODE_W];
      end
      if (mat_latch) begin
        mat_q <= matrix_out;
      end
    end
  end

`ifdef NODE_VOLTAGE_COUNT_EN
  logic [NODE_W:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= '0;
    end else if (state_q == S_WRITE) begin
      count_q <= count_q + {{NODE_W{1'b0}}, 1'b1};
    end
  end

  assign valid_count = count_q;
`endif

  // Matrix column end address: the last row entry of column ref.
  assign matrix_addr = (state_q == S_MREAD)
                     ? MAT_AW'((32'(ref_q) + 32'd1) * (32'(nrn_q) + 32'd1) - 32'd1)
                     : '0;

  assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done              = (state_q == S_DONE);
  assign nodeHeads_addr    = index_q[NODE_W-1:0];
  assign nodeVoltage_addr  = index_q[NODE_W-1:0];
  assign nodeVoltage_wren  = (state_q == S_WRITE);
  assign nodeVoltage_data  = (state_q == S_WRITE) ? fp_to_int_out : 32'd0;
  assign adder_data_a      = off_q;
  assign adder_data_b      = mat_q;
  assign multiplier_data_a = busy ? adder_out : 32'd0;
  assign multiplier_data_b = busy ? scale_q : 32'd0;
  assign fp_to_int_data    = busy ? multiplier_out : 32'd0;
  assign dbg_state         = state_q;

endmodule

// File: doc/node_voltage_engine.md
Name: node_voltage_engine

Overview:
- Parametrised successor to the single-rate node voltage datapath. One start/done handshake walks `num_nodes` node-head entries.
- For each valid head it:
  - reads the reference-node matrix column;
  - computes int(scale × (head_offset + matrix_value)) using the external FP adder, multiplier and fp_to_int IP;
  - writes the result to the nodeVoltage RAM.
- Adds configurable widths, RAM and IP latencies, a runtime scale select, an exact node-count bound (no 32-entry wrap) and a merged internal FSM.

Parameters:
- NODE_W, 5, node index width; max nodes 2^NODE_W.
- HEAD_W, 64, nodeHeads word width; valid bit = HEAD_W-1.
- REF_LSB, 37, LSB of the NODE_W-bit reference-node field in the head word.
- MAT_AW, 12, matrix RAM address width.
- RAM_LAT, 2, cycles from address change to valid RAM data, for both RAMs.
- ADD_LAT, 7, adder latency. MUL_LAT, 5, multiplier latency. CVT_LAT, 6, fp_to_int latency.
- SCALE_CUSTOM, 32'h3F800000, IEEE-754 scale used when scale_sel = 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- scale_sel  in  2  0 = 1.0, 1 = 1e3 (32'h447A0000), 2 = 1e-3 (32'h3A83126F), 3 = SCALE_CUSTOM; latched at start
- num_nodes  in  NODE_W+1  nodes to process; latched at start
- num_ref_nodes  in  NODE_W  matrix columns - 1; latched at start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at pass end
- nodeHeads_addr  out  NODE_W  head RAM address
- nodeHeads_out  in  HEAD_W  head RAM data
- matrix_addr  out  MAT_AW  matrix RAM address
- matrix_out  in  32  matrix RAM data
- nodeVoltage_addr  out  NODE_W  voltage RAM address; equals nodeHeads_addr
- nodeVoltage_data  out  32  fp_to_int result
- nodeVoltage_wren  out  1  write strobe
- adder_data_a, adder_data_b  out  32  registered head offset (bits 31:0) and matrix value
- adder_out  in  32
- multiplier_data_a, multiplier_data_b  out  32  adder_out and latched scale
- multiplier_out  in  32
- fp_to_int_data  out  32  multiplier_out
- fp_to_int_out  in  32

Behaviour:
- **Reset values:** all outputs 0, FSM IDLE, node index 0. A reset mid-pass aborts the pass, drops wren on the next edge, and issues no done.
- **OP_LAT** = ADD_LAT + MUL_LAT + CVT_LAT.
- **FSM states and dwell times:**
  - IDLE → FETCH on start. Start is ignored when busy.
  - FETCH (RAM_LAT cycles): nodeHeads_addr = index.
  - CHECK (1 cycle): if head[HEAD_W-1] = 0 → NEXT. Otherwise latch head[31:0] and ref = head[REF_LSB +: NODE_W] → MREAD.
  - MREAD (RAM_LAT cycles): matrix_addr = (ref+1)*(num_ref_nodes+1) - 1, truncated to MAT_AW. On exit, latch matrix_out.
  - COMPUTE (OP_LAT cycles): adder inputs are held constant.
  - WRITE (1 cycle): nodeVoltage_data = fp_to_int_out, wren = 1.
  - NEXT (1 cycle): index++. If index = num_nodes → DONE, else → FETCH.
  - DONE (1 cycle): done = 1, busy = 0 → IDLE.
- **Cycle counts:**
  - Valid node: 2·RAM_LAT + OP_LAT + 3 cycles.
  - Invalid node: RAM_LAT + 2 cycles; no write, voltage RAM unchanged.
  - done rises (total node cycles + 1) cycles after the start edge.
- **num_nodes = 0:** IDLE → DONE directly; done two cycles after start, no RAM accesses.
- **num_nodes = 2^NODE_W:** all entries processed. Compare uses the NODE_W+1 bit index, so no wrap.
- **Latched inputs:** changes to num_nodes, num_ref_nodes or scale_sel during busy have no effect.
- **Start coincident with DONE:** ignored; a new pass needs start in IDLE.
- **wren:** high only in WRITE. nodeVoltage_addr is stable across the WRITE cycle.

Optional Feature:
- Macro: NODE_VOLTAGE_COUNT_EN.
- **Defined:**
  - Adds output port valid_count [NODE_W:0].
  - Cleared when start is accepted; incremented on each WRITE; holds after done until the next start; reset to 0.
- **Undefined:** port and counter absent; all other behaviour identical.

Test Plan:
- num_nodes = 3, all valid, scale_sel = 1, offset 1.0, matrix 2.0 → three writes of int(3000) at addresses 0,1,2; done at cycle 76 after start with defaults; valid_count = 3.
- num_nodes = 4, nodes 1 and 3 invalid → writes only at 0 and 2; done at cycle 2·25 + 2·4 + 1 = 59.
- num_ref_nodes = 2, head ref field = 4 → matrix_addr = 14 during MREAD; scale_sel = 2, sum 5000.0 → data = 5.
- num_nodes = 0 → done two cycles after start; no wren; busy high exactly one cycle.
- Reset asserted mid-COMPUTE of node 1 → next cycle all outputs 0, no write for node 1, no done; a following start reprocesses from node 0.
- Start pulsed while busy and scale_sel changed mid-pass → ignored; all writes use the originally latched scale; exactly one done.
